// File: rtl/ultra_tiny_cpu.sv
// ultra_tiny_cpu: 8-bit accumulator CPU with a 16-byte serially loaded
// program memory. LOAD=1 loads bytes on WE strobes and holds the CPU in a
// cleared state; LOAD=0 executes one instruction per clock until HLT.
module ultra_tiny_cpu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDH  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_MOVB = 4'h8;
  localparam logic [3:0] OP_SWAP = 4'h9;
  localparam logic [3:0] OP_IN   = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  logic [7:0] mem_q [16];
  logic [3:0] pc_q, pc_d;
  logic [3:0] lp_q, lp_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       halted_q, halted_d;
  logic [7:0] outr_q, outr_d;

  logic       load;
  logic       we;
  logic       mem_we;
  logic [7:0] instr;
  logic [3:0] opcode;
  logic [3:0] n;
  logic [8:0] sum;
  logic       unused;

  assign load   = uio_in[0];
  assign we     = uio_in[1];
  assign mem_we = load & we;
  assign instr  = mem_q[pc_q];
  assign opcode = instr[7:4];
  assign n      = instr[3:0];
  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  assign unused = &{1'b0, ena, uio_in[7:2]};

  assign uo_out  = outr_q;
  assign uio_out = {pc_q, halted_q, 3'b000};
  assign uio_oe  = 8'hF8;

  // Program memory: cleared by reset, written only in load mode on WE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[lp_q] <= ui_in;
    end
  end

  // Next-state: load-mode clearing or single-cycle instruction execution.
  always_comb begin
    pc_d     = pc_q;
    lp_d     = lp_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    z_d      = z_q;
    halted_d = halted_q;
    outr_d   = outr_q;
    if (load) begin
      // CPU state is held cleared while loading; OUTR keeps its value.
      if (we) lp_d = lp_q + 4'd1;
      pc_d     = 4'd0;
      a_d      = 8'h00;
      b_d      = 8'h00;
      c_d      = 1'b0;
      z_d      = 1'b0;
      halted_d = 1'b0;
    end else begin
      lp_d = 4'd0;
      if (!halted_q) begin
        pc_d = pc_q + 4'd1;
        case (opcode)
          OP_NOP: ;
          OP_LDI: begin a_d = {4'h0, n};         z_d = (a_d == 8'h00); end
          OP_LDH: begin a_d = {n, a_q[3:0]};     z_d = (a_d == 8'h00); end
          OP_ADD: begin {c_d, a_d} = sum;        z_d = (a_d == 8'h00); end
          OP_SUB: begin
            a_d = a_q - b_q;
            c_d = (a_q < b_q);
            z_d = (a_d == 8'h00);
          end
          OP_AND: begin a_d = a_q & b_q;         z_d = (a_d == 8'h00); end
          OP_OR:  begin a_d = a_q | b_q;         z_d = (a_d == 8'h00); end
          OP_XOR: begin a_d = a_q ^ b_q;         z_d = (a_d == 8'h00); end
          OP_MOVB: b_d = a_q;
          OP_SWAP: begin a_d = b_q; b_d = a_q;   z_d = (b_q == 8'h00); end
          OP_IN:  begin a_d = ui_in;             z_d = (ui_in == 8'h00); end
          OP_OUT: outr_d = a_q;
          OP_JMP: pc_d = n;
          OP_JZ:  if (z_q) pc_d = n;
          OP_JC:  if (c_q) pc_d = n;
          OP_HLT: begin halted_d = 1'b1; pc_d = pc_q; end
          default: ;
        endcase
      end
    end
  end

  // CPU register file and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= 4'd0;
      lp_q     <= 4'd0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      halted_q <= 1'b0;
      outr_q   <= 8'h00;
    end else begin
      pc_q     <= pc_d;
      lp_q     <= lp_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      z_q      <= z_d;
      halted_q <= halted_d;
      outr_q   <= outr_d;
    end
  end

endmodule

// File: tb/tb_ultra_tiny_cpu.sv
// Directed testbench for ultra_tiny_cpu: loads small programs serially,
// runs them and compares the output pins against hand-computed values.
module tb_ultra_tiny_cpu;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  logic [7:0] prog_q[$];
  logic [7:0] exp_q[$];

  ultra_tiny_cpu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, returning at the following falling edge.
  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
  endtask

  // Serially load prog_q from LP=0, then drop LOAD.
  task automatic load_prog();
    foreach (prog_q[i]) begin
      uio_in = 8'h03;
      ui_in  = prog_q[i];
      step(1);
    end
    uio_in = 8'h00;
    ui_in  = 8'h00;
  endtask

  // Scoreboard: compare uo_out against the oldest expected OUTR value.
  task automatic check_outr(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expected queue empty, got %02h expected value", tag, uo_out);
    end else begin
      e = exp_q.pop_front();
      check(tag, uo_out, e);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset with no clock edge yet
    #2;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hF8);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic program: A=5, B=5, A=3, A=8, OUT, HLT
    prog_q = '{8'h15, 8'h80, 8'h13, 8'h30, 8'hB0, 8'hF0};
    load_prog();
    step(6);
    check("basic_uo", uo_out, 8'h08);
    check("basic_uio", uio_out, 8'h58);
    step(4);
    check("basic_hold_uo", uo_out, 8'h08);
    check("basic_hold_uio", uio_out, 8'h58);

    // Carry/zero: ADD FF+01 -> 00, C=1, Z=1; JC 7 taken
    prog_q = '{8'h1F, 8'h2F, 8'h80, 8'h11, 8'h30, 8'hE7, 8'hF0, 8'h19, 8'hB0, 8'hF0};
    load_prog();
    check("load_keeps_outr", uo_out, 8'h08);
    step(5);
    check("carry_pc5", uio_out, 8'h50);
    step(1);
    check("carry_jc_taken", uio_out, 8'h70);
    step(3);
    check("carry_uo", uo_out, 8'h09);
    check("carry_uio", uio_out, 8'h98);

    // SUB borrow: 2-3 = FF, C=1, Z=0; JZ not taken
    prog_q = '{8'h13, 8'h80, 8'h12, 8'h40, 8'hD6, 8'hB0, 8'hF0};
    load_prog();
    step(6);
    check("sub_uo", uo_out, 8'hFF);
    check("sub_pc6", uio_out, 8'h60);
    step(1);
    check("sub_halt_uio", uio_out, 8'h68);

    // IN/OUT loop
    prog_q = '{8'hA0, 8'hB0, 8'hC0};
    load_prog();
    ui_in = 8'h5A;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    step(1);
    check_outr("io_hold");
    step(1);
    check_outr("io_5a");
    step(1);
    check("io_jmp_pc0", uio_out, 8'h00);
    ui_in = 8'hC3;
    step(3);
    check_outr("io_c3");
    step(1);
    check("io_pc1", uio_out, 8'h10);

    // LOAD mid-run without WE: state clears, OUTR and MEM kept
    uio_in = 8'h01;
    step(1);
    check("midload_uio", uio_out, 8'h00);
    check("midload_uo", uo_out, 8'hC3);
    uio_in = 8'h00;
    ui_in  = 8'h11;
    step(2);
    check("midload_mem_kept", uo_out, 8'h11);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_uo", uo_out, 8'h00);
    check("arst_uio", uio_out, 8'h00);
    check("arst_oe", uio_oe, 8'hF8);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset cleared MEM: all NOPs, PC wraps after 16 edges
    step(5);
    check("nop_pc5", uio_out, 8'h50);
    step(11);
    check("nop_wrap", uio_out, 8'h00);
    check("nop_uo", uo_out, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ultra_tiny_cpu.md
# ultra_tiny_cpu

Tiny 8-bit accumulator CPU for a TinyTapeout-style tile. It holds a 16-entry internal program memory, loaded serially through the dedicated inputs while in load mode. In run mode it executes one instruction per clock. Results appear on the dedicated outputs; PC and halt status appear on the upper bidirectional pins.

## Interface
- No parameters.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: tile-select; ignored by the logic.
- `ui_in` in 8: program byte in load mode; data source for `IN` in run mode.
- `uio_in` in 8: bit0 = LOAD (1 = load mode), bit1 = WE (write strobe in load mode); bits 7:2 ignored.
- `uo_out` out 8: output register OUTR.
- `uio_out` out 8: [7:4] = PC, [3] = HALTED, [2:0] = 0.
- `uio_oe` out 8: constant 8'hF8.

## Operation
- State:
  - MEM[0..15] x 8 bits.
  - PC (4 bits); load pointer LP (4 bits).
  - Registers A and B (8 bits each).
  - Flags C and Z.
  - HALTED.
  - OUTR (8 bits).
- Reset (async) clears all state, including MEM, to 0.
- Load mode (LOAD=1), on each edge:
  - If WE=1: MEM[LP] <= ui_in and LP <= LP+1, wrapping 15->0.
  - PC, A, B, C, Z and HALTED clear to 0; OUTR holds.
- Run mode (LOAD=0):
  - LP clears to 0; WE is ignored.
  - Instruction I = MEM[PC], read combinationally; opcode = I[7:4], n = I[3:0].
  - If HALTED=1, nothing changes.
  - Otherwise one instruction executes per edge. PC <= PC+1 (wrapping 15->0) unless a jump is taken.
- ISA (Z <= (new A == 0) on every instruction that writes A; C changes only on ADD and SUB):
  - 0 NOP.
  - 1 LDI: A <= {0000,n}.
  - 2 LDH: A[7:4] <= n, low nibble kept.
  - 3 ADD: {C,A} <= A+B (9-bit sum).
  - 4 SUB: A <= A-B mod 256; C <= 1 if A<B (borrow).
  - 5 AND, 6 OR, 7 XOR: A <= A op B.
  - 8 MOVB: B <= A; Z unchanged.
  - 9 SWAP: A<->B; Z from the new A.
  - A IN: A <= ui_in.
  - B OUT: OUTR <= A.
  - C JMP: PC <= n.
  - D JZ: PC <= n if Z=1, else PC+1.
  - E JC: PC <= n if C=1, else PC+1.
  - F HLT: HALTED <= 1; PC holds.
- Leaving HALTED requires reset or a LOAD=1 cycle.

## Timing
- Every instruction takes 1 cycle. Its effect is visible on the outputs after the edge that executes it.
- OUTR updates at the OUT edge and holds until the next OUT, or until reset.
- A flag set by instruction k is seen by a conditional jump at instruction k+1.
- LOAD rising mid-run: the next edge clears the CPU state and leaves MEM untouched. Loading restarts at LP=0 only after LOAD has been low for at least one edge.
- LOAD falling: the first run edge executes MEM[0].
- rst_n low forces every output to its reset value immediately, with no clock required: uo_out=0, uio_out=0, uio_oe=F8.

## Test plan
- Reset: rst_n=0 with no clock -> uo_out=00, uio_out=00, uio_oe=F8.
- Basic program: load 15 80 13 30 B0 F0, then LOAD=0 and run 6 cycles -> uo_out=08, HALTED=1, PC=5; further clocks change nothing.
- Carry and zero flags: load 1F 2F 80 11 30 E7 F0 19 B0 F0 and run -> ADD gives A=00 with C=1 and Z=1, the jump to address 7 is taken, final uo_out=09, HALTED=1, PC=9.
- SUB borrow and JZ not taken: load 13 80 12 40 D6 B0 F0 and run -> A=FF, C=1, Z=0; uo_out=FF; halts at PC=6.
- IN/OUT loop: load A0 B0 C0 with ui_in=5A -> uo_out=5A after the 2nd run edge. Change ui_in to C3 -> uo_out=C3 within 3 edges.
- PC wrap and reload:
  - All-NOP memory -> PC reads 0 again after 16 run edges.
  - Raising LOAD mid-run -> PC=0 after one edge and uo_out held.
